// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a 16x32 block memory with one read and one masked write port.
// Zero-fills the memory after reset or on CLEAR, then grants one read and one write per cycle.
module mem_port_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  CLK,
    input  logic                  ARST,
    input  logic                  CLEAR,
    output logic                  BUSY,
    input  logic                  A_VALID,
    input  logic                  B_VALID,
    input  logic                  A_WE,
    input  logic                  B_WE,
    input  logic [ADDR_WIDTH-1:0] A_ADDR,
    input  logic [ADDR_WIDTH-1:0] B_ADDR,
    input  logic [DATA_WIDTH-1:0] A_WDATA,
    input  logic [DATA_WIDTH-1:0] B_WDATA,
    input  logic [DATA_WIDTH-1:0] A_WMASK,
    input  logic [DATA_WIDTH-1:0] B_WMASK,
    output logic                  A_READY,
    output logic                  B_READY,
    output logic                  A_RVALID,
    output logic                  B_RVALID,
    output logic [DATA_WIDTH-1:0] RDATA,
    output logic                  MEM_RD_EN,
    output logic [ADDR_WIDTH-1:0] MEM_RD_ADDR,
    input  logic [DATA_WIDTH-1:0] MEM_RD_DATA,
    output logic [ADDR_WIDTH-1:0] MEM_WR_ADDR,
    output logic [DATA_WIDTH-1:0] MEM_WR_DATA,
    output logic [DATA_WIDTH-1:0] MEM_WR_EN
);

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    logic [0:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  prio_q, prio_d;
    logic                  rv_q, rv_d;
    logic                  rown_q, rown_d;

    logic run;
    logic a_rd, a_wr, b_rd, b_wr;
    logic gnt_a_rd, gnt_b_rd, gnt_a_wr, gnt_b_wr;

    // prio_q = 0 favours A, 1 favours B; it only flips on a contested grant
    always_comb begin
        run      = (state_q == ST_RUN);
        a_rd     = A_VALID & ~A_WE;
        a_wr     = A_VALID & A_WE;
        b_rd     = B_VALID & ~B_WE;
        b_wr     = B_VALID & B_WE;
        gnt_a_rd = run & a_rd & (~b_rd | ~prio_q);
        gnt_b_rd = run & b_rd & (~a_rd | prio_q);
        gnt_a_wr = run & a_wr & (~b_wr | ~prio_q);
        gnt_b_wr = run & b_wr & (~a_wr | prio_q);
        prio_d   = prio_q ^ (run & ((a_rd & b_rd) | (a_wr & b_wr)));
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_INIT) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_ADDR) begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        end else if (CLEAR) begin
            state_d = ST_INIT;
            cnt_d   = '0;
        end
    end

    always_comb begin
        rv_d   = gnt_a_rd | gnt_b_rd;
        rown_d = gnt_b_rd;
    end

    always_ff @(posedge CLK or posedge ARST) begin
        if (ARST) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            prio_q  <= 1'b0;
            rv_q    <= 1'b0;
            rown_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prio_q  <= prio_d;
            rv_q    <= rv_d;
            rown_q  <= rown_d;
        end
    end

    always_comb begin
        BUSY        = ~run;
        A_READY     = gnt_a_rd | gnt_a_wr;
        B_READY     = gnt_b_rd | gnt_b_wr;
        A_RVALID    = rv_q & ~rown_q;
        B_RVALID    = rv_q & rown_q;
        RDATA       = MEM_RD_DATA;
        MEM_RD_EN   = gnt_a_rd | gnt_b_rd;
        MEM_RD_ADDR = gnt_b_rd ? B_ADDR : A_ADDR;
        if (!run) begin
            MEM_WR_ADDR = cnt_q;
            MEM_WR_DATA = '0;
            MEM_WR_EN   = '1;
        end else if (gnt_b_wr) begin
            MEM_WR_ADDR = B_ADDR;
            MEM_WR_DATA = B_WDATA;
            MEM_WR_EN   = B_WMASK;
        end else begin
            MEM_WR_ADDR = A_ADDR;
            MEM_WR_DATA = A_WDATA;
            MEM_WR_EN   = gnt_a_wr ? A_WMASK : '0;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural non-transparent 16x32 memory.
module tb_mem_port_arbiter;

    logic        CLK = 1'b0;
    logic        ARST;
    logic        CLEAR;
    logic        BUSY;
    logic        A_VALID, B_VALID, A_WE, B_WE;
    logic [3:0]  A_ADDR, B_ADDR;
    logic [31:0] A_WDATA, B_WDATA, A_WMASK, B_WMASK;
    logic        A_READY, B_READY, A_RVALID, B_RVALID;
    logic [31:0] RDATA;
    logic        MEM_RD_EN;
    logic [3:0]  MEM_RD_ADDR;
    logic [31:0] MEM_RD_DATA;
    logic [3:0]  MEM_WR_ADDR;
    logic [31:0] MEM_WR_DATA;
    logic [31:0] MEM_WR_EN;

    logic [31:0] mem [16];
    logic        preload;
    int          checks = 0;
    int          errors = 0;

    mem_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) dut (
        .CLK(CLK), .ARST(ARST), .CLEAR(CLEAR), .BUSY(BUSY),
        .A_VALID(A_VALID), .B_VALID(B_VALID), .A_WE(A_WE), .B_WE(B_WE),
        .A_ADDR(A_ADDR), .B_ADDR(B_ADDR),
        .A_WDATA(A_WDATA), .B_WDATA(B_WDATA),
        .A_WMASK(A_WMASK), .B_WMASK(B_WMASK),
        .A_READY(A_READY), .B_READY(B_READY),
        .A_RVALID(A_RVALID), .B_RVALID(B_RVALID), .RDATA(RDATA),
        .MEM_RD_EN(MEM_RD_EN), .MEM_RD_ADDR(MEM_RD_ADDR),
        .MEM_RD_DATA(MEM_RD_DATA), .MEM_WR_ADDR(MEM_WR_ADDR),
        .MEM_WR_DATA(MEM_WR_DATA), .MEM_WR_EN(MEM_WR_EN)
    );

    always #5 CLK = ~CLK;

    // preload garbage so the clear sequence is observable
    always @(posedge CLK) begin
        if (preload) begin
            for (int k = 0; k < 16; k++) mem[k] <= 32'hA5A5A5A0 + k;
        end else begin
            if (MEM_RD_EN) MEM_RD_DATA <= mem[MEM_RD_ADDR];
            mem[MEM_WR_ADDR] <= (mem[MEM_WR_ADDR] & ~MEM_WR_EN) |
                                (MEM_WR_DATA & MEM_WR_EN);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        ARST = 1'b1; preload = 1'b1; CLEAR = 1'b0;
        A_VALID = 1'b1; B_VALID = 1'b1; A_WE = 1'b0; B_WE = 1'b1;
        A_ADDR = '0; B_ADDR = '0;
        A_WDATA = '0; B_WDATA = '0; A_WMASK = '1; B_WMASK = '1;
        MEM_RD_DATA = '0;
        repeat (2) @(posedge CLK);
        preload = 1'b0;
        #1;
        chk("rst_busy", {31'd0, BUSY}, 32'd1);
        chk("rst_a_ready", {31'd0, A_READY}, 32'd0);
        chk("rst_b_ready", {31'd0, B_READY}, 32'd0);
        chk("rst_a_rvalid", {31'd0, A_RVALID}, 32'd0);
        chk("rst_b_rvalid", {31'd0, B_RVALID}, 32'd0);
        chk("rst_rd_en", {31'd0, MEM_RD_EN}, 32'd0);
        chk("rst_wr_en", MEM_WR_EN, 32'hFFFFFFFF);

        A_VALID = 1'b0; B_VALID = 1'b0; B_WE = 1'b0;
        ARST = 1'b0;
        #1;
        for (int i = 0; i < 16; i++) begin
            chk("init_busy", {31'd0, BUSY}, 32'd1);
            chk("init_wr_en", MEM_WR_EN, 32'hFFFFFFFF);
            chk("init_wr_addr", {28'd0, MEM_WR_ADDR}, i);
            chk("init_wr_data", MEM_WR_DATA, 32'd0);
            step();
            #1;
        end
        chk("init_done_busy", {31'd0, BUSY}, 32'd0);

        // A reads address 7
        A_VALID = 1'b1; A_WE = 1'b0; A_ADDR = 4'd7;
        #1;
        chk("rd7_ready", {31'd0, A_READY}, 32'd1);
        chk("rd7_rd_en", {31'd0, MEM_RD_EN}, 32'd1);
        chk("rd7_addr", {28'd0, MEM_RD_ADDR}, 32'd7);
        chk("rd7_wr_en", MEM_WR_EN, 32'd0);
        step();
        A_VALID = 1'b0;
        #1;
        chk("rd7_a_rvalid", {31'd0, A_RVALID}, 32'd1);
        chk("rd7_b_rvalid", {31'd0, B_RVALID}, 32'd0);
        chk("rd7_data", RDATA, 32'd0);

        // masked write then read back
        A_VALID = 1'b1; A_WE = 1'b1; A_ADDR = 4'd3;
        A_WDATA = 32'hDEADBEEF; A_WMASK = 32'hFFFF0000;
        #1;
        chk("wr3_ready", {31'd0, A_READY}, 32'd1);
        chk("wr3_wr_en", MEM_WR_EN, 32'hFFFF0000);
        chk("wr3_wr_data", MEM_WR_DATA, 32'hDEADBEEF);
        chk("wr3_wr_addr", {28'd0, MEM_WR_ADDR}, 32'd3);
        step();
        A_WE = 1'b0;
        #1;
        chk("rd3_ready", {31'd0, A_READY}, 32'd1);
        step();
        A_VALID = 1'b0;
        #1;
        chk("rd3_rvalid", {31'd0, A_RVALID}, 32'd1);
        chk("rd3_data", RDATA, 32'hDEAD0000);

        // contested reads alternate A, B, A, B
        A_VALID = 1'b1; A_WE = 1'b0; A_ADDR = 4'd1;
        B_VALID = 1'b1; B_WE = 1'b0; B_ADDR = 4'd2;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("alt_a_ready", {31'd0, A_READY}, (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("alt_b_ready", {31'd0, B_READY}, (i % 2 == 1) ? 32'd1 : 32'd0);
            chk("alt_rd_addr", {28'd0, MEM_RD_ADDR}, (i % 2 == 0) ? 32'd1 : 32'd2);
            if (i > 0) begin
                chk("alt_a_rvalid", {31'd0, A_RVALID}, (i % 2 == 1) ? 32'd1 : 32'd0);
                chk("alt_b_rvalid", {31'd0, B_RVALID}, (i % 2 == 0) ? 32'd1 : 32'd0);
            end
            step();
        end
        A_VALID = 1'b0; B_VALID = 1'b0;
        #1;
        chk("alt_last_b_rvalid", {31'd0, B_RVALID}, 32'd1);
        chk("alt_last_a_rvalid", {31'd0, A_RVALID}, 32'd0);

        // contested writes: priority is back on A
        A_VALID = 1'b1; A_WE = 1'b1; A_ADDR = 4'd5;
        A_WDATA = 32'h11111111; A_WMASK = 32'hFFFFFFFF;
        B_VALID = 1'b1; B_WE = 1'b1; B_ADDR = 4'd5;
        B_WDATA = 32'h33333333; B_WMASK = 32'h0000FFFF;
        #1;
        chk("wrc_a_ready", {31'd0, A_READY}, 32'd1);
        chk("wrc_b_ready", {31'd0, B_READY}, 32'd0);
        chk("wrc_wr_data", MEM_WR_DATA, 32'h11111111);
        chk("wrc_wr_en", MEM_WR_EN, 32'hFFFFFFFF);
        step();

        // read and write the same address in one cycle
        A_WE = 1'b0;
        B_WDATA = 32'h22222222; B_WMASK = 32'hFFFFFFFF;
        #1;
        chk("rw_a_ready", {31'd0, A_READY}, 32'd1);
        chk("rw_b_ready", {31'd0, B_READY}, 32'd1);
        chk("rw_wr_en", MEM_WR_EN, 32'hFFFFFFFF);
        chk("rw_wr_data", MEM_WR_DATA, 32'h22222222);
        step();
        B_VALID = 1'b0;
        #1;
        chk("rw_a_rvalid", {31'd0, A_RVALID}, 32'd1);
        chk("rw_old_data", RDATA, 32'h11111111);
        step();
        A_VALID = 1'b0;
        #1;
        chk("rw_new_data", RDATA, 32'h22222222);

        // CLEAR while A has a read granted
        A_VALID = 1'b1; A_ADDR = 4'd5; CLEAR = 1'b1;
        #1;
        chk("clr_a_ready", {31'd0, A_READY}, 32'd1);
        step();
        CLEAR = 1'b0;
        #1;
        chk("clr_a_rvalid", {31'd0, A_RVALID}, 32'd1);
        chk("clr_rdata", RDATA, 32'h22222222);
        for (int i = 0; i < 16; i++) begin
            chk("clr_busy", {31'd0, BUSY}, 32'd1);
            chk("clr_a_ready_low", {31'd0, A_READY}, 32'd0);
            chk("clr_wr_addr", {28'd0, MEM_WR_ADDR}, i);
            chk("clr_wr_en", MEM_WR_EN, 32'hFFFFFFFF);
            step();
            #1;
        end
        A_VALID = 1'b0;
        chk("clr_done_busy", {31'd0, BUSY}, 32'd0);
        for (int i = 0; i <= 16; i++) begin
            A_VALID = (i < 16);
            A_ADDR = i[3:0];
            #1;
            if (i > 0) begin
                chk("clr_rb_rvalid", {31'd0, A_RVALID}, 32'd1);
                chk("clr_rb_data", RDATA, 32'd0);
            end
            step();
        end

        // reset right after a read grant
        A_VALID = 1'b1; A_WE = 1'b0; A_ADDR = 4'd3;
        #1;
        chk("ar_a_ready", {31'd0, A_READY}, 32'd1);
        step();
        ARST = 1'b1;
        #1;
        chk("ar_a_rvalid", {31'd0, A_RVALID}, 32'd0);
        chk("ar_busy", {31'd0, BUSY}, 32'd1);
        chk("ar_a_ready", {31'd0, A_READY}, 32'd0);
        chk("ar_rd_en", {31'd0, MEM_RD_EN}, 32'd0);
        chk("ar_wr_en", MEM_WR_EN, 32'hFFFFFFFF);
        chk("ar_wr_addr", {28'd0, MEM_WR_ADDR}, 32'd0);
        step();
        ARST = 1'b0; A_VALID = 1'b0;
        #1;
        chk("ar_rel_wr_addr0", {28'd0, MEM_WR_ADDR}, 32'd0);
        step();
        chk("ar_rel_wr_addr1", {28'd0, MEM_WR_ADDR}, 32'd1);
        chk("ar_rel_busy", {31'd0, BUSY}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Controller that shares the E_Mem tile's 16x32 block memory (one synchronous read port, one bit-masked write port) between two fabric-side requesters, A and B. Each cycle it can grant one read and one write, and settles same-type contention round-robin. It steers read data back to the issuing requester one cycle later. It also runs a clear sequence that zero-fills the memory after reset or on demand.

## Interface
Parameters:
- DATA_WIDTH, 32, memory word width; write mask has the same width.
- ADDR_WIDTH, 4, memory address width; depth = 2**ADDR_WIDTH (16).

Ports:
- CLK  in  1  single clock for the block and the memory ports.
- ARST  in  1  asynchronous, active-high reset.
- CLEAR  in  1  sampled in RUN; starts a zero-fill of the whole memory.
- BUSY  out  1  high while the clear sequence runs.
- A_VALID, B_VALID  in  1  request present.
- A_WE, B_WE  in  1  1 = write, 0 = read.
- A_ADDR, B_ADDR  in  ADDR_WIDTH  request address.
- A_WDATA, B_WDATA  in  DATA_WIDTH  write data.
- A_WMASK, B_WMASK  in  DATA_WIDTH  per-bit write enable.
- A_READY, B_READY  out  1  grant; a request transfers when VALID && READY at a rising edge.
- A_RVALID, B_RVALID  out  1  one-cycle pulse: RDATA holds that requester's read result.
- RDATA  out  DATA_WIDTH  shared read-data bus, driven straight from MEM_RD_DATA.
- MEM_RD_EN  out  1  memory read enable.
- MEM_RD_ADDR  out  ADDR_WIDTH  memory read address.
- MEM_RD_DATA  in  DATA_WIDTH  memory read data, registered in the memory, 1-cycle latency.
- MEM_WR_ADDR  out  ADDR_WIDTH  memory write address.
- MEM_WR_DATA  out  DATA_WIDTH  memory write data.
- MEM_WR_EN  out  DATA_WIDTH  per-bit memory write enable.

## Operation
- FSM states:
  - INIT: clear counter walks 0..DEPTH-1; each cycle drives MEM_WR_ADDR = counter, MEM_WR_DATA = 0, MEM_WR_EN = all ones. After address DEPTH-1 it goes to RUN. BUSY=1, both READYs=0.
  - RUN: arbitration. CLEAR=1 in RUN moves to INIT on the next edge, with the counter reset to 0. Requests presented in that same cycle are still arbitrated and granted normally.
- Arbitration in RUN is combinational from VALID/WE/priority:
  - Requesters of different types (one read, one write): both granted in the same cycle.
  - Same type, both valid: the requester holding priority is granted. Priority then flips to the other requester. Priority changes only on a contested grant.
  - A single valid requester is always granted.
- Write grant: MEM_WR_ADDR/DATA come from the granted requester; MEM_WR_EN = its WMASK. With no write grant, MEM_WR_EN = 0.
- Read grant: MEM_RD_EN=1 and MEM_RD_ADDR come from the granted requester. A 1-bit registered owner tag plus a valid bit produce A_RVALID or B_RVALID in the next cycle.
- A read and a write to the same address in the same cycle are allowed. The memory is non-transparent, so the read returns the pre-write word. No hazard logic.
- A read granted in the last RUN cycle before INIT still returns its RVALID during INIT.
- Outside a grant, MEM_RD_ADDR, MEM_WR_ADDR and MEM_WR_DATA are don't-care. Enables are always well-defined.

## Timing
- Values held while ARST is high: state = INIT, counter = 0, priority = A, BUSY=1, A/B_READY=0, A/B_RVALID=0, MEM_RD_EN=0. MEM_WR_EN=all ones, because INIT drives the first clear write as soon as ARST releases.
- ARST asserted mid-operation clears the in-flight read valid immediately (no RVALID follows) and restarts the clear from address 0.
- The clear takes exactly DEPTH cycles after ARST release (addresses 0..15). READY can assert in cycle DEPTH+1.
- Read latency: grant in cycle t gives RVALID and data in cycle t+1. Back-to-back reads sustain one per cycle.
- Write latency: the write commits at the edge ending its grant cycle. A read granted the next cycle returns the new data.
- READY depends combinationally on VALID. VALID must not depend on READY.

## Test plan
- Reset, then idle: BUSY high for 16 cycles with MEM_WR_EN=FFFFFFFF and addresses 0..15 in order -> BUSY falls. A read of address 7 by A returns 00000000 with A_RVALID one cycle after grant.
- A writes DEADBEEF to address 3 with mask FFFF0000, then A reads address 3 -> RDATA=DEAD0000 one cycle after the read grant.
- A and B both read every cycle for 4 cycles -> grants alternate A, B, A, B. Each RVALID goes to the matching requester one cycle later.
- A reads address 5 (old value 11111111) while B writes 22222222 to address 5 in the same cycle -> both granted. A_RVALID with 11111111; a following read returns 22222222.
- CLEAR pulse while A has a read granted in the same cycle -> A_RVALID still fires. BUSY high for 16 cycles, READY low throughout. All addresses read 0 afterwards.
- ARST asserted the cycle after a read grant -> no RVALID. Outputs take their reset values immediately and the clear restarts from address 0.
